// File: rtl/perceptron_layer_sequencer_if.sv
// Handshake and weight-write bundle for the perceptron layer sequencer.
// The slave side is the sequencer; the master side is the producer/consumer.
interface perceptron_layer_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int M     = 4
);
   localparam int AW = (M > 1) ? $clog2(M) : 1;
   localparam int KW = $clog2(M + 1);

   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] in_x [N];
   logic [KW-1:0]           in_count;
   logic                    w_we;
   logic [AW-1:0]           w_addr;
   logic signed [WIDTH-1:0] w_data [N];
   logic signed [WIDTH-1:0] b_data;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_y [M];
   logic [KW-1:0]           out_count;
   logic                    busy;

   modport slave (
      input  in_valid, in_x, in_count,
      input  w_we, w_addr, w_data, b_data,
      input  out_ready,
      output in_ready, out_valid, out_y,
      output out_count, busy
   );

   modport master (
      output in_valid, in_x, in_count,
      output w_we, w_addr, w_data, b_data,
      output out_ready,
      input  in_ready, out_valid, out_y,
      input  out_count, busy
   );
endinterface

// File: rtl/perceptron_layer_sequencer.sv
// One combinational perceptron shared across up to M neurons of a layer,
// evaluating one neuron per clock from a private weight/bias store.
module perceptron #(
   parameter int WIDTH = 8,
   parameter int N     = 4
) (
   input  logic signed [WIDTH-1:0] x_i [N],
   input  logic signed [WIDTH-1:0] w_i [N],
   input  logic signed [WIDTH-1:0] b_i,
   output logic signed [WIDTH-1:0] y_o
);
   localparam int SW = 2 * WIDTH + $clog2(N + 1) + 1;
   localparam logic signed [SW-1:0] YMAX =
      {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

   logic signed [SW-1:0] acc;

   always_comb begin
      acc = SW'(b_i);
      for (int i = 0; i < N; i++) begin
         acc = acc + SW'(x_i[i]) * SW'(w_i[i]);
      end
      if (acc[SW-1]) begin
         y_o = '0;
      end else if (acc > YMAX) begin
         y_o = YMAX[WIDTH-1:0];
      end else begin
         y_o = acc[WIDTH-1:0];
      end
   end
endmodule

module perceptron_layer_sequencer #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int M     = 4
) (
   input logic clk,
   input logic rst,
   perceptron_layer_sequencer_if.slave bus
);
   localparam int AW = (M > 1) ? $clog2(M) : 1;
   localparam int KW = $clog2(M + 1);
   localparam logic [KW-1:0] KMAX = KW'(M);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e                  state_q;
   logic signed [WIDTH-1:0] x_q [N];
   logic signed [WIDTH-1:0] w_q [M][N];
   logic signed [WIDTH-1:0] b_q [M];
   logic signed [WIDTH-1:0] y_q [M];
   logic [AW-1:0]           k_q;
   logic [KW-1:0]           cnt_q;
   logic [KW-1:0]           ocnt_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic                    busy_q;

   logic [KW-1:0]           cnt_d;
   logic signed [WIDTH-1:0] w_row [N];
   logic signed [WIDTH-1:0] b_sel;
   logic signed [WIDTH-1:0] y;
   logic                    w_ok;
   logic                    last;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_row[i] = w_q[k_q][i];
      end
      b_sel = b_q[k_q];
   end

   perceptron #(.WIDTH(WIDTH), .N(N)) u_pe (
      .x_i (x_q),
      .w_i (w_row),
      .b_i (b_sel),
      .y_o (y)
   );

   // zero or oversized counts mean "the whole layer"
   assign cnt_d = (bus.in_count == '0 || bus.in_count > KMAX)
                ? KMAX : bus.in_count;
   assign w_ok  = (state_q == IDLE) && bus.w_we
               && ({1'b0, bus.w_addr} < (AW+1)'(M));
   assign last  = (KW'(k_q) == cnt_q - KW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         cnt_q       <= '0;
         ocnt_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < N; i++) begin
            x_q[i] <= '0;
         end
         for (int j = 0; j < M; j++) begin
            b_q[j] <= '0;
            y_q[j] <= '0;
            for (int i = 0; i < N; i++) begin
               w_q[j][i] <= '0;
            end
         end
      end else begin
         if (w_ok) begin
            w_q[bus.w_addr] <= bus.w_data;
            b_q[bus.w_addr] <= bus.b_data;
         end
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  x_q        <= bus.in_x;
                  cnt_q      <= cnt_d;
                  k_q        <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
                  for (int j = 0; j < M; j++) begin
                     y_q[j] <= '0;
                  end
               end
            end
            RUN: begin
               y_q[k_q] <= y;
               if (last) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  ocnt_q      <= cnt_q;
               end else begin
                  k_q <= k_q + AW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_y     = y_q;
   assign bus.out_count = ocnt_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_perceptron_layer_sequencer.sv
// Directed bench for perceptron_layer_sequencer: weights, runs,
// backpressure, blocked writes and mid-run reset.
module tb_perceptron_layer_sequencer;
   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int M     = 4;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   lat;

   perceptron_layer_sequencer_if #(
      .WIDTH(WIDTH), .N(N), .M(M)
   ) bus ();

   perceptron_layer_sequencer #(
      .WIDTH(WIDTH), .N(N), .M(M)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag,
                      input logic signed [31:0] obs,
                      input logic signed [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wrow(input int a, input int w0, input int w1,
                       input int w2, input int w3, input int b);
      bus.w_we      = 1'b1;
      bus.w_addr    = a[1:0];
      bus.w_data[0] = w0[7:0];
      bus.w_data[1] = w1[7:0];
      bus.w_data[2] = w2[7:0];
      bus.w_data[3] = w3[7:0];
      bus.b_data    = b[7:0];
      step();
      bus.w_we = 1'b0;
   endtask

   task automatic set_x(input int x0, input int x1,
                        input int x2, input int x3, input int cnt);
      bus.in_x[0]  = x0[7:0];
      bus.in_x[1]  = x1[7:0];
      bus.in_x[2]  = x2[7:0];
      bus.in_x[3]  = x3[7:0];
      bus.in_count = cnt[2:0];
   endtask

   // latency counts the accept cycle as cycle 1
   task automatic wait_done(input int start, output int l);
      l = -1;
      for (int i = start + 1; i <= start + 20; i++) begin
         step();
         if (bus.out_valid === 1'b1) begin
            l = i;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input int x0, input int x1,
                      input int x2, input int x3, input int cnt,
                      input int exp_lat);
      int l;
      set_x(x0, x1, x2, x3, cnt);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      wait_done(1, l);
      chk({tag, "_lat"}, l, exp_lat);
   endtask

   task automatic chk_y(input string tag, input int y0, input int y1,
                        input int y2, input int y3, input int cnt);
      int e[4];
      e = '{y0, y1, y2, y3};
      for (int i = 0; i < M; i++) begin
         chk($sformatf("%s_y%0d", tag, i), bus.out_y[i], e[i]);
      end
      chk({tag, "_cnt"}, bus.out_count, cnt);
   endtask

   task automatic drain(input string tag);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk({tag, "_rdy"}, bus.in_ready, 1);
      chk({tag, "_vld"}, bus.out_valid, 0);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.w_we     = 1'b0;
      bus.w_addr   = '0;
      bus.b_data   = '0;
      for (int i = 0; i < N; i++) begin
         bus.w_data[i] = '0;
      end
      set_x(0, 0, 0, 0, 0);
      step();
      step();
      rst = 1'b0;
      chk("rst_rdy", bus.in_ready, 1);
      chk("rst_vld", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk_y("rst", 0, 0, 0, 0, 0);
      step();
      chk("idle_rdy", bus.in_ready, 1);

      wrow(0, 1, 2, 3, 0, 1);
      wrow(1, 1, 1, 1, 1, 0);
      wrow(2, -1, -1, -1, -1, 0);
      wrow(3, 0, 0, 0, 0, 5);

      run("basic", 1, 1, 1, 1, 4, 5);
      chk("basic_busy", bus.busy, 1);
      chk_y("basic", 7, 4, 0, 5, 4);
      drain("basic");

      run("part", 1, 1, 1, 1, 2, 3);
      chk_y("part", 7, 4, 0, 0, 2);
      drain("part");

      run("zero", 1, 1, 1, 1, 0, 5);
      chk_y("zero", 7, 4, 0, 5, 4);
      drain("zero");

      // saturation at +127 and count above M clamps to M
      run("sat", 127, 127, 127, 127, 7, 5);
      chk_y("sat", 127, 127, 0, 5, 4);
      drain("sat");

      run("bp", 1, 1, 1, 1, 4, 5);
      set_x(2, 0, 0, 0, 4);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("bp_rdy", bus.in_ready, 0);
         chk("bp_vld", bus.out_valid, 1);
         chk("bp_y0", bus.out_y[0], 7);
         chk("bp_y3", bus.out_y[3], 5);
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("bp_rel_rdy", bus.in_ready, 1);
      chk("bp_rel_vld", bus.out_valid, 0);
      step();
      bus.in_valid = 1'b0;
      chk("bp_acc_rdy", bus.in_ready, 0);
      chk("bp_acc_busy", bus.busy, 1);
      wait_done(1, lat);
      chk("bp2_lat", lat, 5);
      chk_y("bp2", 3, 2, 0, 5, 4);
      drain("bp2");

      set_x(1, 1, 1, 1, 4);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      wrow(1, 9, 9, 9, 9, 9);
      wait_done(2, lat);
      chk("blk_lat", lat, 5);
      chk_y("blk", 7, 4, 0, 5, 4);
      drain("blk");
      run("blk2", 1, 1, 1, 1, 4, 5);
      chk("blk2_y1", bus.out_y[1], 4);
      drain("blk2");

      set_x(1, 1, 1, 1, 4);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_rdy", bus.in_ready, 1);
      chk("mrst_vld", bus.out_valid, 0);
      chk("mrst_busy", bus.busy, 0);
      chk("mrst_y0", bus.out_y[0], 0);
      chk("mrst_cnt", bus.out_count, 0);
      run("clr", 1, 1, 1, 1, 4, 5);
      chk_y("clr", 0, 0, 0, 0, 4);
      drain("clr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
